// File: rtl/can_rx.sv
// CAN 2.0A receiver: bus sampling, destuffing, frame parsing, CRC-15 check and ACK drive.
// Optional acceptance filtering is enabled by defining ADDR_FILTER_EN.
module can_rx #(
  parameter int unsigned IDLE_BITS   = 11,
  parameter logic [10:0] FILTER_ID   = 11'h000,
  parameter logic [10:0] FILTER_MASK = 11'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_clk,
  input  logic        rx,
  output logic [10:0] address,
  output logic [3:0]  dlc,
  output logic [63:0] data,
  output logic        rtr,
  output logic        rx_valid,
  output logic        rxing,
  output logic        ack_drive,
  output logic        crc_err,
  output logic        stuff_err,
  output logic        form_err
);

  typedef enum logic [3:0] {
    IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, WAIT_IDLE
  } state_t;

  localparam logic [15:0] IDLE_LIM = 16'(IDLE_BITS);

  state_t      state, state_n;
  logic        baud_s1, baud_s2, baud_d, rx_s1, rx_s2;
  logic        strobe, smp, stuff_win, fail_form, fail_stuff, accept;
  logic [6:0]  cnt, cnt_n, nbits, nbits_n, nb;
  logic        run_val, run_val_n;
  logic [2:0]  run_cnt, run_cnt_n;
  logic [15:0] idle_cnt, idle_cnt_n;
  logic [10:0] id_sr, id_sr_n, address_n;
  logic        rtr_sr, rtr_sr_n, rtr_n;
  logic [3:0]  dlc_sr, dlc_sr_n, dlc_n;
  logic [63:0] data_sr, data_sr_n, data_n;
  logic [14:0] crc_calc, crc_calc_n, crc_rx, crc_rx_n;
  logic        crc_ok, crc_ok_n;
  logic        rx_valid_n, ack_drive_n, crc_err_n, stuff_err_n, form_err_n;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic [14:0] s;
    s = {c[13:0], 1'b0};
    if (b ^ c[14]) s = s ^ 15'h4599;
    return s;
  endfunction

`ifdef ADDR_FILTER_EN
  assign accept = ((id_sr & FILTER_MASK) == (FILTER_ID & FILTER_MASK));
`else
  logic filter_unused;
  assign filter_unused = ^{FILTER_ID, FILTER_MASK};
  assign accept = 1'b1;
`endif

  assign strobe    = baud_s2 & ~baud_d;
  assign smp       = rx_s2;
  assign rxing     = (state != IDLE);
  // The CRC delimiter is outside the destuffing window, so a run of five
  // ending on the last CRC bit is not followed by a stuff bit.
  assign stuff_win = (state == ARB) || (state == CTRL) || (state == DATA) || (state == CRC);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    nbits_n     = nbits;
    run_val_n   = run_val;
    run_cnt_n   = run_cnt;
    idle_cnt_n  = idle_cnt;
    id_sr_n     = id_sr;
    rtr_sr_n    = rtr_sr;
    dlc_sr_n    = dlc_sr;
    data_sr_n   = data_sr;
    crc_calc_n  = crc_calc;
    crc_rx_n    = crc_rx;
    crc_ok_n    = crc_ok;
    address_n   = address;
    dlc_n       = dlc;
    data_n      = data;
    rtr_n       = rtr;
    rx_valid_n  = 1'b0;
    ack_drive_n = ack_drive;
    crc_err_n   = crc_err;
    stuff_err_n = stuff_err;
    form_err_n  = form_err;
    fail_form   = 1'b0;
    fail_stuff  = 1'b0;
    nb          = '0;

    if (strobe) begin
      if (stuff_win && run_cnt == 3'd5) begin
        fail_stuff = (smp == run_val);
        run_val_n  = smp;
        run_cnt_n  = 3'd1;
      end else begin
        if (smp == run_val && run_cnt != 3'd5) begin
          run_cnt_n = run_cnt + 3'd1;
        end else begin
          run_val_n = smp;
          run_cnt_n = 3'd1;
        end

        case (state)
          IDLE: begin
            if (!smp) begin
              state_n     = ARB;
              cnt_n       = '0;
              run_val_n   = 1'b0;
              run_cnt_n   = 3'd1;
              id_sr_n     = '0;
              rtr_sr_n    = 1'b0;
              dlc_sr_n    = '0;
              data_sr_n   = '0;
              crc_calc_n  = '0;
              crc_rx_n    = '0;
              crc_ok_n    = 1'b0;
              crc_err_n   = 1'b0;
              stuff_err_n = 1'b0;
              form_err_n  = 1'b0;
            end
          end
          ARB: begin
            crc_calc_n = crc_step(crc_calc, smp);
            if (cnt == 7'd11) begin
              rtr_sr_n = smp;
              state_n  = CTRL;
              cnt_n    = '0;
            end else begin
              id_sr_n = {id_sr[9:0], smp};
              cnt_n   = cnt + 7'd1;
            end
          end
          CTRL: begin
            crc_calc_n = crc_step(crc_calc, smp);
            cnt_n      = cnt + 7'd1;
            if (cnt == 7'd0) begin
              fail_form = smp;
            end else if (cnt != 7'd1) begin
              dlc_sr_n = {dlc_sr[2:0], smp};
              if (cnt == 7'd5) begin
                nb      = rtr_sr ? 7'd0
                        : (dlc_sr_n[3] ? 7'd64 : {1'b0, dlc_sr_n[2:0], 3'b000});
                nbits_n = nb;
                cnt_n   = '0;
                state_n = (nb == 7'd0) ? CRC : DATA;
              end
            end
          end
          DATA: begin
            crc_calc_n = crc_step(crc_calc, smp);
            data_sr_n  = {data_sr[62:0], smp};
            if (cnt == nbits - 7'd1) begin
              state_n = CRC;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 7'd1;
            end
          end
          CRC: begin
            crc_rx_n = {crc_rx[13:0], smp};
            if (cnt == 7'd14) begin
              state_n = CRC_DEL;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 7'd1;
            end
          end
          CRC_DEL: begin
            if (!smp) begin
              fail_form = 1'b1;
            end else begin
              state_n     = ACK;
              crc_ok_n    = (crc_rx == crc_calc);
              ack_drive_n = (crc_rx == crc_calc);
              crc_err_n   = (crc_rx != crc_calc);
            end
          end
          ACK: begin
            ack_drive_n = 1'b0;
            state_n     = ACK_DEL;
          end
          ACK_DEL: begin
            fail_form = ~smp;
            state_n   = EOF;
            cnt_n     = '0;
          end
          EOF: begin
            fail_form = ~smp;
            if (cnt == 7'd6) begin
              state_n = IDLE;
              if (crc_ok && accept) begin
                address_n  = id_sr;
                dlc_n      = dlc_sr;
                data_n     = data_sr;
                rtr_n      = rtr_sr;
                rx_valid_n = 1'b1;
              end
            end else begin
              cnt_n = cnt + 7'd1;
            end
          end
          WAIT_IDLE: begin
            if (smp) begin
              if (idle_cnt + 16'd1 >= IDLE_LIM) state_n = IDLE;
              idle_cnt_n = idle_cnt + 16'd1;
            end else begin
              idle_cnt_n = '0;
            end
          end
          default: state_n = IDLE;
        endcase
      end

      if (fail_form || fail_stuff) begin
        form_err_n  = form_err | fail_form;
        stuff_err_n = stuff_err | fail_stuff;
        rx_valid_n  = 1'b0;
        ack_drive_n = 1'b0;
        idle_cnt_n  = '0;
        state_n     = WAIT_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_s1   <= 1'b0;
      baud_s2   <= 1'b0;
      baud_d    <= 1'b0;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      nbits     <= '0;
      run_val   <= 1'b0;
      run_cnt   <= '0;
      idle_cnt  <= '0;
      id_sr     <= '0;
      rtr_sr    <= 1'b0;
      dlc_sr    <= '0;
      data_sr   <= '0;
      crc_calc  <= '0;
      crc_rx    <= '0;
      crc_ok    <= 1'b0;
      address   <= '0;
      dlc       <= '0;
      data      <= '0;
      rtr       <= 1'b0;
      rx_valid  <= 1'b0;
      ack_drive <= 1'b0;
      crc_err   <= 1'b0;
      stuff_err <= 1'b0;
      form_err  <= 1'b0;
    end else begin
      baud_s1   <= baud_clk;
      baud_s2   <= baud_s1;
      baud_d    <= baud_s2;
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      state     <= state_n;
      cnt       <= cnt_n;
      nbits     <= nbits_n;
      run_val   <= run_val_n;
      run_cnt   <= run_cnt_n;
      idle_cnt  <= idle_cnt_n;
      id_sr     <= id_sr_n;
      rtr_sr    <= rtr_sr_n;
      dlc_sr    <= dlc_sr_n;
      data_sr   <= data_sr_n;
      crc_calc  <= crc_calc_n;
      crc_rx    <= crc_rx_n;
      crc_ok    <= crc_ok_n;
      address   <= address_n;
      dlc       <= dlc_n;
      data      <= data_n;
      rtr       <= rtr_n;
      rx_valid  <= rx_valid_n;
      ack_drive <= ack_drive_n;
      crc_err   <= crc_err_n;
      stuff_err <= stuff_err_n;
      form_err  <= form_err_n;
    end
  end

endmodule

// File: tb/tb_can_rx.sv
// Bench for can_rx: frames are built bit by bit from field values, stuffed and
// driven on rx with a slow baud_clk; results are checked against table entries and a frame model.
module tb_can_rx;

  logic        clk = 1'b0, rst = 1'b0, baud_clk = 1'b0, rx = 1'b1;
  logic [10:0] address;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic        rtr, rx_valid, rxing, ack_drive, crc_err, stuff_err, form_err;

  can_rx #(.IDLE_BITS(11), .FILTER_ID(11'h028), .FILTER_MASK(11'h7FF)) dut (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .rx(rx),
    .address(address), .dlc(dlc), .data(data), .rtr(rtr),
    .rx_valid(rx_valid), .rxing(rxing), .ack_drive(ack_drive),
    .crc_err(crc_err), .stuff_err(stuff_err), .form_err(form_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int valid_cnt = 0, ack_cycles = 0, ack_rise_edge = -1, ack_rise_bit = -1;
  int edge_cnt = 0, cur_bit = -1, del_idx = 0;
  logic ack_prev = 1'b0;
  logic tx_q[$];

  // Held outputs of the last accepted frame.
  logic [10:0] m_addr = '0;
  logic [3:0]  m_dlc = '0;
  logic [63:0] m_data = '0;
  logic        m_rtr = 1'b0;

  always @(posedge baud_clk) edge_cnt = 0;
  always @(posedge clk) begin
    #1;
    edge_cnt++;
    if (rx_valid) valid_cnt++;
    if (ack_drive) ack_cycles++;
    if (ack_drive && !ack_prev) begin
      ack_rise_edge = edge_cnt;
      ack_rise_bit  = cur_bit;
    end
    ack_prev = ack_drive;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int idx);
    rx = b;
    cur_bit = idx;
    #40 baud_clk = 1'b1;
    #40 baud_clk = 1'b0;
  endtask

  function automatic int n_bytes(input logic r, input logic [3:0] d);
    if (r) return 0;
    return (d > 4'd8) ? 8 : int'(d);
  endfunction

  // kind: 0 good, 1 one CRC bit flipped, 2 dominant EOF bit 3
  task automatic build(input logic [10:0] id, input logic r, input logic [3:0] d,
                       input logic [63:0] pay, input int kind);
    logic raw[$];
    int crc, nb, same, fb;
    logic last;
    raw = {};
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(r);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(d[i]);
    nb = n_bytes(r, d);
    for (int i = 8 * nb - 1; i >= 0; i--) raw.push_back(pay[i]);
    crc = 0;
    foreach (raw[i]) begin
      fb  = int'(raw[i]) ^ ((crc >> 14) & 1);
      crc = ((crc << 1) ^ (fb != 0 ? 'h4599 : 0)) & 'h7FFF;
    end
    for (int i = 14; i >= 0; i--)
      raw.push_back(1'(((crc >> i) & 1) ^ ((kind == 1 && i == 3) ? 1 : 0)));
    tx_q = {};
    same = 0;
    last = 1'b1;
    foreach (raw[i]) begin
      if (same == 5) begin
        tx_q.push_back(~last);
        last = ~last;
        same = 1;
      end
      if (raw[i] == last) same++;
      else begin
        last = raw[i];
        same = 1;
      end
      tx_q.push_back(raw[i]);
    end
    del_idx = tx_q.size();
    for (int i = 0; i < 3; i++) tx_q.push_back(1'b1);
    for (int i = 0; i < 7; i++) tx_q.push_back(!(kind == 2 && i == 2));
    for (int i = 0; i < 12; i++) tx_q.push_back(1'b1);
  endtask

  task automatic send_frame();
    valid_cnt = 0;
    ack_cycles = 0;
    ack_rise_edge = -1;
    ack_rise_bit = -1;
    foreach (tx_q[i]) send_bit(tx_q[i], i);
    cur_bit = -1;
  endtask

  task automatic check_out(input string tag, input int e_valid, input logic [10:0] e_addr,
                           input logic [3:0] e_dlc, input logic e_rtr, input logic [63:0] e_data,
                           input logic e_crc, input logic e_form, input logic e_ack);
    chk({tag, "/valid"}, 64'(valid_cnt), 64'(e_valid));
    chk({tag, "/address"}, 64'(address), 64'(e_addr));
    chk({tag, "/dlc"}, 64'(dlc), 64'(e_dlc));
    chk({tag, "/rtr"}, 64'(rtr), 64'(e_rtr));
    chk({tag, "/data"}, data, e_data);
    chk({tag, "/flags"}, {61'd0, crc_err, stuff_err, form_err}, {61'd0, e_crc, 1'b0, e_form});
    chk({tag, "/rxing"}, 64'(rxing), 64'd0);
    if (e_ack) begin
      chk({tag, "/ack_len"}, 64'(ack_cycles), 64'd8);
      chk({tag, "/ack_edge"}, 64'(ack_rise_edge), 64'd3);
      chk({tag, "/ack_bit"}, 64'(ack_rise_bit), 64'(del_idx));
    end else begin
      chk({tag, "/ack_len"}, 64'(ack_cycles), 64'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "/address"}, 64'(address), 64'd0);
    chk({tag, "/dlc"}, 64'(dlc), 64'd0);
    chk({tag, "/data"}, data, 64'd0);
    chk({tag, "/ctl"}, 64'({rtr, rx_valid, rxing, ack_drive, crc_err, stuff_err, form_err}), 64'd0);
  endtask

  function automatic logic accepted(input logic [10:0] id);
`ifdef ADDR_FILTER_EN
    return (id & 11'h7FF) == (11'h028 & 11'h7FF);
`else
    return (id == id);
`endif
  endfunction

  task automatic model_frame(input string tag, input logic [10:0] id, input logic r,
                             input logic [3:0] d, input logic [63:0] pay, input int kind);
    int nb;
    logic [63:0] mask;
    logic ok;
    build(id, r, d, pay, kind);
    send_frame();
    nb   = n_bytes(r, d);
    mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    ok   = (kind != 1) && (kind != 2) && accepted(id);
    if (ok) begin
      m_addr = id;
      m_dlc  = d;
      m_rtr  = r;
      m_data = pay & mask;
    end
    check_out(tag, ok ? 1 : 0, m_addr, m_dlc, m_rtr, m_data, kind == 1, kind == 2, kind != 1);
  endtask

  typedef struct {
    logic [10:0] id;
    logic        r;
    logic [3:0]  d;
    logic [63:0] pay;
    int          kind;
    int          e_valid;
    logic [10:0] e_addr;
    logic [3:0]  e_dlc;
    logic        e_rtr;
    logic [63:0] e_data;
    logic        e_crc;
    logic        e_form;
    logic        e_ack;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{11'h028, 1'b0, 4'd8, 64'd43, 0, 1, 11'h028, 4'd8, 1'b0, 64'd43, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{11'h000, 1'b0, 4'd2, 64'hA5C3, 0, 1, 11'h000, 4'd2, 1'b0, 64'hA5C3, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{11'h155, 1'b0, 4'd4, 64'hDEADBEEF, 1, 0, 11'h000, 4'd2, 1'b0, 64'hA5C3, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{11'h123, 1'b1, 4'd4, 64'h1122334455667788, 0, 1, 11'h123, 4'd4, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{11'h7FF, 1'b0, 4'hF, 64'h0123456789ABCDEF, 0, 1, 11'h7FF, 4'hF, 1'b0, 64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{11'h3A5, 1'b0, 4'd0, 64'hFFFFFFFFFFFFFFFF, 0, 1, 11'h3A5, 4'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{11'h0F0, 1'b0, 4'd1, 64'h5A, 2, 0, 11'h3A5, 4'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1};
`ifdef ADDR_FILTER_EN
    tbl[0].e_valid = 1;
    tbl[1] = '{11'h000, 1'b0, 4'd2, 64'hA5C3, 0, 0, 11'h028, 4'd8, 1'b0, 64'd43, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{11'h155, 1'b0, 4'd4, 64'hDEADBEEF, 1, 0, 11'h028, 4'd8, 1'b0, 64'd43, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{11'h123, 1'b1, 4'd4, 64'h1122334455667788, 0, 0, 11'h028, 4'd8, 1'b0, 64'd43, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{11'h7FF, 1'b0, 4'hF, 64'h0123456789ABCDEF, 0, 0, 11'h028, 4'd8, 1'b0, 64'd43, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{11'h3A5, 1'b0, 4'd0, 64'hFFFFFFFFFFFFFFFF, 0, 0, 11'h028, 4'd8, 1'b0, 64'd43, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{11'h0F0, 1'b0, 4'd1, 64'h5A, 2, 0, 11'h028, 4'd8, 1'b0, 64'd43, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{11'h029, 1'b0, 4'd1, 64'h77, 0, 0, 11'h028, 4'd8, 1'b0, 64'd43, 1'b0, 1'b0, 1'b1};
`else
    tbl[7] = '{11'h029, 1'b0, 4'd1, 64'h77, 0, 1, 11'h029, 4'd1, 1'b0, 64'h77, 1'b0, 1'b0, 1'b1};
`endif
    tbl[8] = '{11'h028, 1'b0, 4'd3, 64'hABCDEF, 0, 1, 11'h028, 4'd3, 1'b0, 64'hABCDEF, 1'b0, 1'b0, 1'b1};

    #20;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 12; i++) send_bit(1'b1, -1);

    foreach (tbl[i]) begin
      build(tbl[i].id, tbl[i].r, tbl[i].d, tbl[i].pay, tbl[i].kind);
      send_frame();
      check_out($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_addr, tbl[i].e_dlc,
                tbl[i].e_rtr, tbl[i].e_data, tbl[i].e_crc, tbl[i].e_form, tbl[i].e_ack);
      if (tbl[i].e_valid == 1) begin
        m_addr = tbl[i].e_addr;
        m_dlc  = tbl[i].e_dlc;
        m_rtr  = tbl[i].e_rtr;
        m_data = tbl[i].e_data;
      end
    end

    // Stuff violation: a sixth dominant bit where the stuff bit belongs.
    build(11'h000, 1'b0, 4'd0, 64'd0, 0);
    valid_cnt = 0;
    for (int i = 0; i < 5; i++) send_bit(tx_q[i], i);
    send_bit(1'b0, 5);
    chk("stuff/err", 64'(stuff_err), 64'd1);
    chk("stuff/rxing_err", 64'(rxing), 64'd1);
    for (int i = 0; i < 10; i++) send_bit(1'b1, -1);
    chk("stuff/rxing_10", 64'(rxing), 64'd1);
    send_bit(1'b1, -1);
    chk("stuff/rxing_11", 64'(rxing), 64'd0);
    chk("stuff/err_held", 64'(stuff_err), 64'd1);
    chk("stuff/valid", 64'(valid_cnt), 64'd0);
    chk("stuff/address", 64'(address), 64'(m_addr));
    chk("stuff/data", data, m_data);

    // Reset in the middle of the data field.
    build(11'h028, 1'b0, 4'd8, 64'hFEDCBA9876543210, 0);
    for (int i = 0; i < 30; i++) send_bit(tx_q[i], i);
    #3 rst = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    m_addr = '0;
    m_dlc  = '0;
    m_rtr  = 1'b0;
    m_data = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) send_bit(1'b1, -1);
    model_frame("post_reset", 11'h028, 1'b0, 4'd8, 64'd43, 0);

    for (int n = 0; n < 12; n++) begin
      logic [10:0] rid;
      logic        rr;
      logic [3:0]  rd;
      logic [63:0] rp;
      int          rk;
      rid = 11'($urandom);
      rr  = ($urandom_range(0, 3) == 0);
      rd  = 4'($urandom);
      rp  = {$urandom, $urandom};
      rk  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      model_frame($sformatf("rnd%0d", n), rid, rr, rd, rp, rk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/can_rx.md
Name: can_rx

Overview:
- CAN 2.0A (standard 11-bit ID) frame receiver; the receive-side counterpart of can_tx.
- Samples the bus bit stream and removes stuff bits.
- Parses SOF through EOF, checks CRC-15, drives the ACK slot and presents the received ID, DLC and payload.
- Sits between the transceiver rx pin and the host logic, on the same clk / baud_clk pair as can_tx.

Parameters:
- IDLE_BITS, 11, consecutive recessive samples required to leave WAIT_IDLE.
- FILTER_ID, 11'h000, acceptance ID; used only with ADDR_FILTER_EN.
- FILTER_MASK, 11'h000, acceptance mask, 1 = bit compared; used only with ADDR_FILTER_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- baud_clk  input  1  bit-rate clock, asynchronous to clk.
- rx  input  1  bus level; 1 = recessive.
- address  output  11  ID of the last good frame.
- dlc  output  4  DLC field of the last good frame, as received.
- data  output  64  payload of the last good frame.
- rtr  output  1  RTR bit of the last good frame.
- rx_valid  output  1  one-clk pulse when a good frame completes.
- rxing  output  1  high from SOF until return to IDLE.
- ack_drive  output  1  high = force dominant during the ACK slot.
- crc_err  output  1  sticky; cleared at next SOF.
- stuff_err  output  1  sticky; cleared at next SOF.
- form_err  output  1  sticky; cleared at next SOF.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift registers 0, CRC 0.
- Sampling:
  - baud_clk and rx each pass through a 2-flop synchronizer.
  - A rising edge of synchronized baud_clk produces a one-clk strobe; synchronized rx is taken on that strobe.
  - Latency from baud_clk rise to sample is 3 clk.
  - can_tx launches bits on the falling edge, so samples land mid-bit.
- Destuffing:
  - Applies from SOF through the last CRC bit.
  - After 5 equal consecutive raw bits, the next bit is a stuff bit and is discarded.
  - If the stuff bit equals the previous bit: set stuff_err and go to WAIT_IDLE.
  - The run counter restarts at 1 with the stuff bit as the new run value.
- CRC:
  - CRC-15, polynomial 0x4599, init 0.
  - Computed over destuffed bits from SOF through the last data bit.
  - The 15 received CRC bits are compared with the computed CRC.
- States, advancing on destuffed-bit strobes:
  - IDLE: sample 0 = SOF. Clear error flags, set rxing, go to ARB.
  - ARB: 11 ID bits (MSB first), then the RTR bit; go to CTRL.
  - CTRL: IDE, r0, then 4 DLC bits.
    - IDE=1: form_err, go to WAIT_IDLE.
    - Byte count = 0 if RTR=1; otherwise min(DLC, 8).
    - Byte count 0 goes straight to CRC; otherwise go to DATA.
  - DATA: 8 x byte-count bits, shifted in at data[0]. Unused upper bits are 0 (right-justified; the last bit received is at data[0]).
  - CRC: 15 bits, then CRC_DEL.
  - CRC_DEL: sample must be 1, else form_err and WAIT_IDLE. On a CRC match, ack_drive goes high on this strobe.
  - ACK: ack_drive goes low on this strobe; the sample value is ignored.
  - ACK_DEL: must be 1, else form_err.
  - EOF: 7 bits, each must be 1, else form_err.
    - After the 7th bit with CRC matched: latch address, dlc, rtr and data; pulse rx_valid for 1 clk; go to IDLE.
  - CRC mismatch at CRC_DEL: set crc_err, no ack_drive. The frame still tracks through EOF; at completion there is no latch and no rx_valid, and the state returns to IDLE.
  - WAIT_IDLE: rxing high. Return to IDLE after IDLE_BITS consecutive 1 samples; a 0 sample restarts the count.
- Output holding: address, dlc, rtr and data hold until the next good frame.
- Reset mid-frame: immediate return to IDLE; the partial frame is discarded.
- Simultaneous events: a strobe in the same clk as reset deassertion is ignored.

Optional Feature:
- Macro ADDR_FILTER_EN.
- Defined:
  - Accept only if (ID & FILTER_MASK) == (FILTER_ID & FILTER_MASK).
  - Rejected frames are still checked and ACKed.
  - Rejected frames produce no latch and no rx_valid; rxing and error flags behave normally.
- Undefined: every good frame is latched; FILTER_* parameters are ignored.

Test Plan:
- Loopback with can_tx: address 11'h28, data 64'd43, DLC 8 -> rx_valid once; address=11'h28, data=64'd43, dlc=8, no error flags.
- Stuff check: ID 11'h000 (forces stuff bits) -> correct ID. A stuff bit forced to equal the previous bit -> stuff_err=1, no rx_valid, IDLE only after 11 recessive bits.
- CRC corruption: flip one CRC bit -> crc_err=1, ack_drive never high, no rx_valid, previous address/data unchanged.
- Boundaries:
  - RTR=1 with DLC=4 -> rx_valid, rtr=1, data=0.
  - DLC=4'hF -> 8 bytes received, dlc=15.
  - DLC=0 -> data=0.
- ACK timing: good frame -> ack_drive high for exactly one baud period, starting 3 clk after the CRC-delimiter baud_clk rise. A form error (0 in EOF bit 3) -> form_err=1.
- Reset: assert rst low mid-DATA -> all outputs 0 at once. After release, the next frame is received correctly.
- ADDR_FILTER_EN defined with FILTER_ID=11'h28, FILTER_MASK=11'h7FF: ID 11'h29 -> no rx_valid; ID 11'h28 -> rx_valid.
